// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared states, header layout and strobe decoder for the frame sequencer
package frame_cfg_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STROBE, HOLD} state_e;
  localparam logic [7:0] MAGIC = 8'hFA;
  localparam int MAGIC_HI = 31;
  localparam int MAGIC_LO = 24;
  localparam int START_HI = 20;
  localparam int START_LO = 16;
  localparam int CNT_HI = 4;
  localparam int CNT_LO = 0;
  function automatic logic [31:0] frame_onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: turns a header-framed word stream into FrameData/FrameStrobe latch cycles
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles = 2,
  parameter int HoldCycles = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [FrameBitsPerRow-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       abort,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int CW = 8;
  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic done_q, done_d, err_q, err_d;
  logic [5:0] hdr_end;
  logic hdr_ok;
  assign hdr_end = 6'(in_data[START_HI:START_LO]) + 6'(in_data[CNT_HI:CNT_LO]) + 6'd1;
  assign hdr_ok = (in_data[MAGIC_HI:MAGIC_LO] == MAGIC) && (hdr_end <= 6'(MaxFramesPerCol));
  assign in_ready = !RST && (state_q == IDLE || state_q == FETCH);
  assign busy = state_q != IDLE;
  assign FrameData = data_q;
  assign FrameStrobe = strobe_q;
  assign done = done_q;
  assign err = err_q;
  // next state: abort from any busy state beats everything, including a same-cycle fetch
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    data_d = data_q;
    strobe_d = strobe_q;
    done_d = 1'b0;
    err_d = err_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      strobe_d = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          err_d = !hdr_ok;
          if (hdr_ok) begin
            state_d = FETCH;
            idx_d = in_data[START_HI:START_LO];
            rem_d = in_data[CNT_HI:CNT_LO];
          end
        end
        FETCH: if (in_valid) begin
          data_d = in_data;
          state_d = SETUP;
        end
        SETUP: begin
          state_d = STROBE;
          strobe_d = MaxFramesPerCol'(frame_onehot(idx_q));
          cnt_d = CW'(StrobeCycles - 1);
        end
        STROBE: if (cnt_q == '0) begin
          state_d = HOLD;
          strobe_d = '0;
          cnt_d = CW'(HoldCycles - 1);
        end else cnt_d = cnt_q - CW'(1);
        HOLD: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (rem_q == '0) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          state_d = FETCH;
          idx_d = idx_q + 5'd1;
          rem_d = rem_q - 5'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and output registers; reset clears the strobe immediately
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      strobe_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      strobe_q <= strobe_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_frame_config_sequencer.sv
// tb_frame_config_sequencer: scoreboard bench for the frame configuration sequencer
module tb_frame_config_sequencer;
  typedef struct {
    logic [19:0] s;
    logic [31:0] d;
    int w;
  } exp_t;
  logic CLK = 1'b0;
  logic RST;
  logic [31:0] in_data;
  logic in_valid;
  logic in_ready;
  logic abort;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic busy;
  logic done;
  logic err;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sq[$];
  logic [19:0] dq[$];

  frame_config_sequencer dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [19:0] s, input logic [31:0] d, input int w);
    exp_t e;
    e.s = s;
    e.d = d;
    e.w = w;
    sq.push_back(e);
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_data = w;
    in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic gap(input int cycles);
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("gap_ready", 32'(in_ready), 32'd1);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sq.size() != 0 || dq.size() != 0 || busy) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 32'(n < 300), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  // monitor: pops expected frames on strobe rise and expected done tokens on done
  initial begin
    logic [19:0] prev_s, last_s;
    logic [31:0] prev_d;
    exp_t cur;
    int width;
    prev_s = '0;
    last_s = '0;
    prev_d = '0;
    width = 0;
    cur.s = '0;
    cur.d = '0;
    cur.w = 0;
    forever begin
      @(negedge CLK);
      if (FrameStrobe != '0 && prev_s == '0) begin
        chk("strobe_onehot", 32'($onehot(FrameStrobe)), 32'd1);
        if (sq.size() == 0) chk("unexpected_strobe", 32'(FrameStrobe), 32'd0);
        else begin
          cur = sq.pop_front();
          chk("strobe_idx", 32'(FrameStrobe), 32'(cur.s));
          chk("strobe_data", FrameData, cur.d);
          chk("data_before_strobe", prev_d, cur.d);
        end
        width = 1;
        last_s = FrameStrobe;
      end else if (FrameStrobe != '0) begin
        chk("strobe_stable", 32'(FrameStrobe), 32'(prev_s));
        width++;
      end else if (prev_s != '0) begin
        chk("strobe_width", 32'(width), 32'(cur.w));
        if (cur.w == 2) chk("data_hold", FrameData, prev_d);
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else chk("done_last_frame", 32'(last_s), 32'(dq.pop_front()));
      end
      prev_s = FrameStrobe;
      prev_d = FrameData;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    abort = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_data", FrameData, 32'd0);
    chk("rst_strobe", 32'(FrameStrobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    // single frame at index 3
    push_frame(20'h00008, 32'hDEADBEEF, 2);
    dq.push_back(20'h00008);
    send(32'hFA03_0000);
    chk("t1_busy_after_hdr", 32'(busy), 32'd1);
    send(32'hDEADBEEF);
    wait_idle();
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    // three frames with input gaps
    push_frame(20'h00001, 32'hAAAA_0001, 2);
    push_frame(20'h00002, 32'hBBBB_0002, 2);
    push_frame(20'h00004, 32'hCCCC_0003, 2);
    dq.push_back(20'h00004);
    send(32'hFA00_0002);
    send(32'hAAAA_0001);
    gap(3);
    send(32'hBBBB_0002);
    gap(3);
    send(32'hCCCC_0003);
    wait_idle();
    // header rejection
    send(32'hFB00_0000);
    chk("t3_bad_magic_err", 32'(err), 32'd1);
    chk("t3_bad_magic_busy", 32'(busy), 32'd0);
    send(32'hFA13_0001);
    chk("t3_overflow_err", 32'(err), 32'd1);
    chk("t3_overflow_busy", 32'(busy), 32'd0);
    push_frame(20'h00001, 32'h1234_5678, 2);
    dq.push_back(20'h00001);
    send(32'hFA00_0000);
    chk("t3_good_err", 32'(err), 32'd0);
    send(32'h1234_5678);
    wait_idle();
    // abort on first strobe cycle of frame 1 of 3
    push_frame(20'h00001, 32'h0BAD_F00D, 1);
    send(32'hFA00_0002);
    send(32'h0BAD_F00D);
    @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
    chk("t4_strobe", 32'(FrameStrobe), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_data_kept", FrameData, 32'h0BAD_F00D);
    chk("t4_err", 32'(err), 32'd0);
    push_frame(20'h00020, 32'h5555_AAAA, 2);
    dq.push_back(20'h00020);
    send(32'hFA05_0000);
    send(32'h5555_AAAA);
    wait_idle();
    // asynchronous reset in the middle of a strobe
    push_frame(20'h00004, 32'hC0FF_EE00, 1);
    send(32'hFA02_0000);
    send(32'hC0FF_EE00);
    @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("t5_strobe_async", 32'(FrameStrobe), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_ready_async", 32'(in_ready), 32'd0);
    @(negedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("t5_busy_after", 32'(busy), 32'd0);
    chk("t5_data_after", FrameData, 32'd0);
    chk("t5_ready_after", 32'(in_ready), 32'd1);
    chk("t5_err_after", 32'(err), 32'd0);
    // full column, 20 frames
    for (int i = 0; i < 20; i++) push_frame(20'(1 << i), 32'h1000_0000 + 32'(i), 2);
    dq.push_back(20'h80000);
    send(32'hFA00_0013);
    for (int i = 0; i < 20; i++) send(32'h1000_0000 + 32'(i));
    wait_idle();
    chk("t6_err", 32'(err), 32'd0);
    chk("sq_empty", 32'(sq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_config_sequencer.md
Name: frame_config_sequencer

Overview:
Sequences one tile column's configuration frame latches. It takes a header-framed word stream (from the bitstream loader) and drives the column's FrameData/FrameStrobe bus. For each frame it presents the data word, then pulses exactly one FrameStrobe bit for a programmed width, then holds the data. It sits between the config word source and the per-tile ConfigMem blocks of one column.

Parameters:
MaxFramesPerCol, 20, number of frame strobes in the column (max 32).
FrameBitsPerRow, 32, frame data width; must be >= 32.
StrobeCycles, 2, cycles FrameStrobe stays high per frame (>= 1).
HoldCycles, 1, cycles FrameData is held after the strobe falls (>= 1).

Ports:
CLK  input  1  clock; all logic is on the rising edge.
RST  input  1  asynchronous, active-high reset.
in_data  input  FrameBitsPerRow  header or frame word.
in_valid  input  1  in_data is valid.
in_ready  output  1  the block accepts in_data; a transfer occurs when in_valid and in_ready are both high.
abort  input  1  synchronous request to cancel the packet.
FrameData  output  FrameBitsPerRow  registered frame word to the ConfigMem blocks.
FrameStrobe  output  MaxFramesPerCol  registered strobe; one-hot or all zero.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when the last frame's HOLD completes.
err  output  1  sticky; set on a rejected header, cleared on the next accepted header.

Behaviour:
- Reset (asynchronous, RST=1):
  - state=IDLE.
  - FrameData=0, FrameStrobe=0, done=0, err=0, busy=0.
  - in_ready is forced to 0 while RST=1.
- in_ready is 1 only in IDLE and FETCH and only when RST=0. It does not depend on in_valid.
- Header fields:
  - [31:24] magic = 8'hFA.
  - [20:16] start frame index.
  - [4:0] count_m1; frames to load = count_m1+1.
  - All other bits are ignored.
- IDLE, header accepted:
  - Valid if magic matches and start+count_m1+1 <= MaxFramesPerCol. Compute the sum at 6 bits so it never wraps.
  - Valid header: idx<=start, remaining<=count_m1, err<=0, next state FETCH.
  - Invalid header: err<=1, stay IDLE; the following words are treated as headers.
- FETCH: on a transfer, FrameData<=in_data and next state SETUP. Otherwise stay in FETCH; gaps in in_valid are unbounded.
- SETUP: lasts 1 cycle; FrameStrobe=0 and the data settles. Next state STROBE.
- STROBE:
  - FrameStrobe is registered: it becomes (1<<idx) on the edge entering STROBE.
  - FrameStrobe stays at that value for exactly StrobeCycles cycles, counted by a strobe/hold counter.
  - It falls to 0 on the edge leaving STROBE.
- HOLD: lasts HoldCycles cycles; FrameStrobe=0 and FrameData is unchanged. At the end:
  - remaining==0: go to IDLE and set done=1 for that one cycle.
  - otherwise: idx++, remaining--, go to FETCH.
- FrameData changes only on FETCH transfers and on reset. It is never modified while any strobe bit is high.
- Per-frame timing, with defaults and in_valid held high:
  - data accepted in cycle t;
  - SETUP in t+1;
  - strobe visible in t+2 and t+3;
  - HOLD in t+4;
  - next FETCH in t+5.
- abort, sampled in any non-IDLE state:
  - Next state is IDLE and FrameStrobe<=0 on the same edge.
  - done is not pulsed and err is unchanged.
  - FrameData keeps its value.
  - abort has no effect in IDLE.
  - If abort and a FETCH transfer occur in the same cycle, abort wins and the word is consumed and dropped.
- Reset mid-operation: the strobe clears asynchronously; no partial frame is resumed after reset is released.
- A header is never interpreted as frame data, and frame data is never interpreted as a header, except after an abort or a rejected header.

Decomposition:
- Shared package frame_cfg_pkg:
  - state enum {IDLE, FETCH, SETUP, STROBE, HOLD};
  - magic constant 8'hFA;
  - header field bit positions.
- No sub-module is needed. The strobe/hold down-counter is kept inline.
- The one-hot decoder is a function in the package: idx to MaxFramesPerCol bits.

Test Plan:
1. Single frame: header 32'hFA03_0000 (start 3, count 1), then word 32'hDEADBEEF.
   - FrameData=DEADBEEF one cycle before FrameStrobe=20'h00008.
   - Strobe is high for exactly 2 cycles and FrameData is held 1 further cycle.
   - done pulses once; err=0.
2. Multi-frame with gaps: header start 0, count_m1=2 (3 frames), words A, B, C with in_valid low 3 cycles between words.
   - Strobes 0x1, 0x2, 0x4 in order and never overlap.
   - Each strobe coincides with its own word; a single done follows frame 2.
3. Header rejection:
   - Magic 8'hFB -> err=1, no strobe, busy=0.
   - Then start 19, count_m1=1 (sum 21 > 20) -> err stays 1, no strobe.
   - Then a valid header -> err=0.
4. Abort in STROBE: assert abort on the first strobe cycle of frame 1 of 3.
   - Next cycle FrameStrobe=0 and state IDLE; no done.
   - The next word is decoded as a header.
5. Reset mid-STROBE: assert RST asynchronously between clock edges.
   - FrameStrobe, busy and in_ready drop to 0 immediately.
   - After release: IDLE, FrameData=0.
6. Exact boundary: header start 0, count_m1=19.
   - All 20 strobes are issued in order, ending at 20'h80000; done pulses; err=0.
